// File: rtl/click_pkg.sv
// Shared types and helpers for the click round-robin merge.
package click_pkg;

  // Widest pending vector rr_pick accepts; instances use the low N_REQ bits.
  localparam int unsigned MAX_REQ = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    RELEASE
  } arb_state_t;

  // Channel index width; a single bit is kept even for one channel.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First pending index after 'last', wrapping modulo n (not a power of two).
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] pending,
                                          input int unsigned         last,
                                          input int unsigned         n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    idx   = last;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      idx = idx + 1;
      if (idx >= n) idx = 0;
      if (!found && pending[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/click_sync.sv
// Multi-stage flop chain bringing asynchronous phase toggles into clk.
module click_sync #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the input through STAGES flops; reset loads the idle phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/click_rr_merge.sv
// Round-robin merge of N_REQ two-phase click channels onto one click output.
module click_rr_merge
  import click_pkg::*;
#(
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned DATA_WIDTH  = 7,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  logic        PHASE_INIT  = 1'b0,
  localparam int unsigned ID_W        = id_width(N_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  in_req,
  output logic [N_REQ-1:0]                  in_ack,
  input  logic [N_REQ*(DATA_WIDTH+1)-1:0]   in_data,
  output logic                              out_req,
  input  logic                              out_ack,
  output logic [DATA_WIDTH:0]               out_data,
  output logic [ID_W-1:0]                   out_id,
  output logic                              busy
);

  arb_state_t           state;
  logic [ID_W-1:0]      last_grant;
  logic [N_REQ-1:0]     in_req_s;
  logic                 out_ack_s;
  logic [N_REQ-1:0]     pending;
  logic [MAX_REQ-1:0]   pending_ext;
  logic                 any_pending;
  logic                 out_done;
  logic [ID_W-1:0]      grant;
  logic [DATA_WIDTH:0]  data_arr [N_REQ];

  click_sync #(
    .WIDTH  (N_REQ),
    .STAGES (SYNC_STAGES),
    .RST_VAL({N_REQ{PHASE_INIT}})
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (in_req),
    .q  (in_req_s)
  );

  click_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES),
    .RST_VAL(PHASE_INIT)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (out_ack),
    .q  (out_ack_s)
  );

  assign pending     = in_req_s ^ in_ack;
  assign any_pending = |pending;
  assign out_done    = (out_ack_s == out_req);

  // Pick the next pending channel after the last one served.
  always_comb begin
    pending_ext              = '0;
    pending_ext[N_REQ-1:0]   = pending;
    grant = ID_W'(rr_pick(pending_ext, 32'(last_grant), N_REQ));
  end

  // Split the bundled input data into per-channel words.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      data_arr[i] = in_data[i*(DATA_WIDTH+1) +: (DATA_WIDTH+1)];
    end
  end

  // Arbitration FSM: grant, wait for downstream ack, then acknowledge upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_req    <= PHASE_INIT;
      in_ack     <= {N_REQ{PHASE_INIT}};
      out_data   <= '0;
      out_id     <= '0;
      busy       <= 1'b0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_pending) begin
            out_data <= data_arr[grant];
            out_id   <= grant;
            out_req  <= ~out_req;
            busy     <= 1'b1;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (out_done) begin
            in_ack[out_id] <= ~in_ack[out_id];
            last_grant     <= out_id;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          // Guard cycle so the just-cleared pending bit is visible before
          // the next arbitration.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_click_rr_merge.sv
// Self-checking bench for click_rr_merge with a transfer-level reference model.
module tb_click_rr_merge;

  localparam int N  = 4;
  localparam int DW = 7;
  localparam int SS = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     in_req;
  logic [N-1:0]     in_ack;
  logic [N*(DW+1)-1:0] in_data;
  logic             out_req;
  logic             out_ack;
  logic [DW:0]      out_data;
  logic [1:0]       out_id;
  logic             busy;

  logic [7:0]       ch_data [N];

  // Reference model: phases and round-robin history at transfer level.
  logic [N-1:0]     ack_ph;
  logic             out_ph;
  int               last_served;

  int n_cmp;
  int n_bad;

  click_rr_merge #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS),
    .PHASE_INIT (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_req  (in_req),
    .in_ack  (in_ack),
    .in_data (in_data),
    .out_req (out_req),
    .out_ack (out_ack),
    .out_data(out_data),
    .out_id  (out_id),
    .busy    (busy)
  );

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next channel in round-robin order after 'last' among those in 'mask'.
  function automatic int rr_next(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (mask[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    out_ph      = 1'b0;
    ack_ph      = '0;
    last_served = N - 1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    in_req  = '0;
    out_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic request(input int c, input logic [7:0] d);
    assert (in_req[c] == ack_ph[c])
      else $error("protocol violation: channel %0d toggled while pending", c);
    ch_data[c] = d;
    in_req[c]  = ~in_req[c];
  endtask

  // Wait for the next out_req toggle and check the granted transfer.
  task automatic wait_grant(input int exp_id, input int exp_lat);
    int lat;
    lat = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (out_req !== out_ph) begin
        lat = cyc;
        break;
      end
    end
    if (lat == 0) begin
      chk("grant_timeout", 32'd0, 32'd1);
    end else begin
      if (exp_lat > 0) chk("grant_latency", lat, exp_lat);
      chk("out_id", out_id, exp_id);
      chk("out_data", out_data, ch_data[exp_id]);
      chk("busy_grant", busy, 1);
      chk("in_ack_at_grant", in_ack, ack_ph);
    end
    out_ph = ~out_ph;
  endtask

  // Hold the ack back for 'hold' cycles, then echo it and check completion.
  task automatic finish(input int exp_id, input int hold);
    int lat;
    logic [N-1:0] exp_ack;
    for (int d = 0; d < hold; d++) begin
      tick();
      chk("hold_out_req", out_req, out_ph);
      chk("hold_out_data", out_data, ch_data[exp_id]);
      chk("hold_out_id", out_id, exp_id);
      chk("hold_in_ack", in_ack, ack_ph);
    end
    out_ack = ~out_ack;
    exp_ack = ack_ph;
    exp_ack[exp_id] = ~exp_ack[exp_id];
    lat = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (in_ack !== ack_ph) begin
        lat = cyc;
        break;
      end
    end
    if (lat == 0) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("ack_latency", lat, SS + 1);
      chk("in_ack", in_ack, exp_ack);
      chk("busy_release", busy, 1);
      tick();
      chk("busy_idle", busy, 0);
    end
    ack_ph      = exp_ack;
    last_served = exp_id;
  endtask

  // Serve every channel of 'mask' (all requested together) in round-robin order.
  task automatic serve_mask(input logic [N-1:0] mask, input int first_lat);
    logic [N-1:0] m;
    bit first;
    m = mask;
    first = 1'b1;
    while (m != '0) begin
      int c;
      c = rr_next(m, last_served);
      wait_grant(c, first ? first_lat : 0);
      finish(c, $urandom_range(0, 4));
      m[c] = 1'b0;
      first = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] mask;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < N; i++) ch_data[i] = '0;
    rst     = 1'b1;
    in_req  = '0;
    out_ack = 1'b0;
    model_reset();

    // Reset state then a single request on channel 2
    do_reset();
    chk("rst_out_req", out_req, 0);
    chk("rst_in_ack", in_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_data", out_data, 0);
    request(2, 8'h5A);
    wait_grant(2, SS + 1);
    finish(2, 3);

    // All four channels at once, from reset: expect 0,1,2,3
    do_reset();
    for (int i = 0; i < N; i++) request(i, 8'h10 + 8'(i));
    serve_mask(4'b1111, SS + 1);
    repeat (10) tick();
    chk("no_extra_req", out_req, out_ph);
    chk("idle_busy", busy, 0);

    // Fairness: channels 0 and 3 re-request right after each ack
    request(0, 8'($urandom));
    request(3, 8'($urandom));
    mask = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      int c;
      c = rr_next(mask, last_served);
      wait_grant(c, 0);
      finish(c, $urandom_range(0, 3));
      if (i < 18) request(c, 8'($urandom));
      else mask[c] = 1'b0;
    end

    // Back-pressure: ack withheld 50 cycles while channel 1 waits
    request(3, 8'($urandom));
    wait_grant(3, SS + 1);
    request(1, 8'($urandom));
    finish(3, 50);
    wait_grant(1, 0);
    finish(1, 2);

    // Reset during WAIT_ACK
    request(2, 8'($urandom));
    wait_grant(2, SS + 1);
    repeat (2) tick();
    rst     = 1'b1;
    in_req  = '0;
    out_ack = 1'b0;
    tick();
    chk("midrst_out_req", out_req, 0);
    chk("midrst_in_ack", in_ack, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_id", out_id, 0);
    chk("midrst_out_data", out_data, 0);
    rst = 1'b0;
    model_reset();
    request(1, 8'($urandom));
    wait_grant(1, SS + 1);
    finish(1, 1);

    // Spurious acks while idle
    repeat (3) tick();
    for (int t = 0; t < 2; t++) begin
      out_ack = ~out_ack;
      repeat (6) begin
        tick();
        chk("spur_busy", busy, 0);
        chk("spur_in_ack", in_ack, ack_ph);
        chk("spur_out_req", out_req, out_ph);
      end
    end

    // Randomized batches of simultaneous requests
    repeat (12) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) if (mask[i]) request(i, 8'($urandom));
      serve_mask(mask, SS + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/click_rr_merge.md
Name: click_rr_merge

Overview:
- Clocked round-robin arbiter that shares one two-phase click output channel between N_REQ two-phase click input channels, with bundled data.
- Sits between several asynchronous click pipelines and a single downstream click pipeline, or a synchronous consumer behind a click adapter.
- Synchronises incoming req/ack toggles and grants one pending channel at a time.
- Forwards that channel's data, then completes the input handshake only after the output handshake closes.

Parameters:
- N_REQ, 4, number of input channels (>=2).
- DATA_WIDTH, 7, MSB index of data; data buses are DATA_WIDTH+1 bits wide, per the click convention.
- SYNC_STAGES, 2, flop depth of the req/ack synchronisers (>=2).
- PHASE_INIT, 0, reset value of out_req and of every in_ack bit.

Ports:
- clk  input  1  system clock; all state is on posedge clk.
- rst  input  1  synchronous, active-high reset.
- in_req  input  N_REQ  two-phase request toggle, one per channel; asynchronous to clk.
- in_ack  output  N_REQ  two-phase acknowledge toggle, one per channel.
- in_data  input  N_REQ*(DATA_WIDTH+1)  bundled data; channel i occupies slice i; stable while channel i is pending.
- out_req  output  1  two-phase request toggle to downstream.
- out_ack  input  1  two-phase acknowledge from downstream; asynchronous to clk.
- out_data  output  DATA_WIDTH+1  registered data for the current transfer.
- out_id  output  $clog2(N_REQ)  index of the channel owning the current transfer.
- busy  output  1  high while a transfer is outstanding (state WAIT_ACK or RELEASE).

Behaviour:
- Reset, synchronous and active-high: out_req=PHASE_INIT, in_ack=all PHASE_INIT, out_data=0, out_id=0, busy=0, state=IDLE, last_grant=N_REQ-1 so that channel 0 wins first. Synchroniser flops reset to PHASE_INIT.
- Synchronisation: in_req_s = in_req delayed through SYNC_STAGES flops. out_ack_s is synchronised the same way.
- pending[i] = in_req_s[i] ^ in_ack[i]. out_done = (out_ack_s == out_req).
- IDLE: if any pending bit is set, grant g = first pending index scanning from last_grant+1 upward with wrap-around modulo N_REQ.
  - Next cycle: out_data <= in_data[g], out_id <= g, out_req toggles, busy=1, state -> WAIT_ACK.
  - Latency: one clk from pending seen to out_req toggle. Minimum end-to-end latency is SYNC_STAGES+1 cycles from the in_req edge.
- WAIT_ACK: hold out_req, out_data and out_id stable. When out_done: in_ack[out_id] toggles, last_grant <= out_id, state -> RELEASE.
- RELEASE: one-cycle guard; busy=1; state -> IDLE; no grant is issued in this cycle. This lets the cleared pending bit settle before the next arbitration.
- At most one in_ack bit toggles per cycle. in_ack of a non-granted channel never changes.
- Simultaneous pending: strict round-robin. A channel that just completed has the lowest priority on the next arbitration. Any channel waits at most N_REQ-1 transfers.
- A channel that becomes pending while another is granted is served later. Its request is never lost, because pending is level-derived from the toggle mismatch.
- A new in_req toggle on a channel already pending violates the protocol. Behaviour is undefined; the bench flags it as an assertion.
- An out_ack toggle when no transfer is outstanding is ignored: out_done is already true and the state is IDLE.
- Reset asserted mid-transfer forces all outputs to reset values on the next edge. In-flight handshakes are dropped; the environment must reset its phases too.
- out_id width: use 1 bit when N_REQ=2. The wrap-around arithmetic is modulo N_REQ, not modulo a power of two.

Decomposition:
- Package click_pkg holds:
  - the arb_state_t enum {IDLE, WAIT_ACK, RELEASE};
  - the function rr_pick(pending, last) returning the grant index;
  - the localparam ID_W = (N_REQ>1) ? $clog2(N_REQ) : 1, computed per instance.
- One sub-module, click_sync: WIDTH-bit, STAGES-deep synchronous flop chain with synchronous reset value. It is instantiated twice: once for in_req (N_REQ bits) and once for out_ack (1 bit).

Test Plan:
- Reset then single request: toggle in_req[2] with data 0x5A, downstream echoes the ack after 3 cycles.
  - out_req toggles at cycle SYNC_STAGES+1 after the in_req edge, with out_data=0x5A and out_id=2.
  - in_ack[2] toggles one cycle after out_ack_s matches; busy falls after RELEASE.
- Simultaneous requests: toggle all 4 in_req on the same edge with data 0x10, 0x11, 0x12, 0x13.
  - out_id sequence is 0, 1, 2, 3; out_data matches each channel; exactly four out_req toggles.
- Round-robin fairness: channels 0 and 3 re-request immediately after each ack for 20 transfers.
  - Grants alternate 0, 3, 0, 3...; no channel is granted twice in a row while the other is pending.
- Back-pressure: downstream withholds out_ack for 50 cycles while channel 1 is pending.
  - out_req, out_data and out_id are held stable for all 50 cycles and no in_ack toggles.
  - Channel 1 is then served next.
- Reset mid-transfer: assert rst for 1 cycle during WAIT_ACK.
  - Next cycle: out_req=PHASE_INIT, in_ack=0000, busy=0, out_id=0.
  - A fresh request on channel 1 is then served normally.
- Spurious ack: toggle out_ack twice while in IDLE with no requests.
  - No state change, busy stays 0, no in_ack activity.
